// File: rtl/ram4w16b_bist.sv
// March-style built-in self-test initiator for one RAM4W16B instance.
// Sequence: write P to every word; per word read P then write ~P; read ~P from every word.
module ram4w16b_bist #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    output logic [WIDTH-1:0] ram_in,
    output logic [AW-1:0]    ram_addr,
    output logic             ram_load,
    input  logic [WIDTH-1:0] ram_out,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [AW-1:0]    fail_addr,
    output logic [WIDTH-1:0] fail_data
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] W0   = 3'd1;
    localparam logic [2:0] R0   = 3'd2;
    localparam logic [2:0] W1   = 3'd3;
    localparam logic [2:0] R1   = 3'd4;
    localparam logic [2:0] DONE = 3'd5;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [2:0]       state;
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] pat;
    logic [WIDTH-1:0] expected;
    logic             mismatch;

    // Read phases compare against P (first read pass) or ~P (second read pass)
    always_comb begin
        expected = (state == R0) ? pat : ~pat;
        mismatch = ((state == R0) || (state == R1)) && (ram_out != expected);
    end

    // Bus drive decodes only registered state, so nothing from inputs reaches outputs
    always_comb begin
        ram_load = (state == W0) || (state == W1);
        ram_addr = ((state == IDLE) || (state == DONE)) ? '0 : a;
        ram_in   = '0;
        if (state == W0)
            ram_in = pat;
        else if (state == W1)
            ram_in = ~pat;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            a         <= '0;
            pat       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
        end else begin
            // Only the first mismatch of a run is captured; the run never aborts
            if (mismatch) begin
                fail <= 1'b1;
                if (!fail) begin
                    fail_addr <= a;
                    fail_data <= ram_out;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        pat       <= pattern;
                        done      <= 1'b0;
                        fail      <= 1'b0;
                        fail_addr <= '0;
                        fail_data <= '0;
                        busy      <= 1'b1;
                        a         <= '0;
                        state     <= W0;
                    end
                end
                W0: begin
                    if (a == LAST) begin
                        a     <= '0;
                        state <= R0;
                    end else begin
                        a <= a + AW'(1);
                    end
                end
                R0: begin
                    state <= W1;
                end
                W1: begin
                    if (a == LAST) begin
                        a     <= '0;
                        state <= R1;
                    end else begin
                        a     <= a + AW'(1);
                        state <= R0;
                    end
                end
                R1: begin
                    if (a == LAST) begin
                        a     <= '0;
                        state <= DONE;
                    end else begin
                        a <= a + AW'(1);
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
